serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_pkg.sv | 18 +
 rtl/serial_alu_if.sv | 24 ++
 rtl/serial_alu_bit.sv | 11 +
 rtl/serial_alu_ctrl.sv | 101 ++++++++++
 tb/tb_serial_alu_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared FSM state encodings, opcode encodings and counter sizing for serial_alu_ctrl
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit counter must hold the value WIDTH itself so it never wraps
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// serial_alu_if: operation request/result bundle; the op signal exists only when SERIAL_ALU_SUB_EN is defined
interface serial_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
`ifdef SERIAL_ALU_SUB_EN
    logic             op;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

`ifdef SERIAL_ALU_SUB_EN
    modport master (output start, op, a, b, input busy, done, result, cout, overflow);
    modport slave  (input start, op, a, b, output busy, done, result, cout, overflow);
`else
    modport master (output start, a, b, input busy, done, result, cout, overflow);
    modport slave  (input start, a, b, output busy, done, result, cout, overflow);
`endif
endinterface

// File: rtl/serial_alu_bit.sv
// serial_alu_bit: combinational 1-bit full-adder cell shared across all bit positions
module serial_alu_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ cin_i;
    assign carry_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial add (and subtract when SERIAL_ALU_SUB_EN is defined), LSB first, one bit per cycle
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_alu_if.slave   alu
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cmsb_q, cout_q, ovf_q, done_q;
    logic             accept, last, b_bit, s_bit, c_bit;
`ifdef SERIAL_ALU_SUB_EN
    logic             op_q;

    assign b_bit = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
`else
    assign b_bit = b_q[0];
`endif

    serial_alu_bit u_bit (
        .a_i     (a_q[0]),
        .b_i     (b_bit),
        .cin_i   (carry_q),
        .sum_o   (s_bit),
        .carry_o (c_bit)
    );

    // Next state: start is honoured in IDLE and DONE, ignored while RUN
    always_comb begin
        last    = (cnt_q == CW'(WIDTH - 1));
        accept  = alu.start && (state_q != RUN);
        state_d = (state_q == RUN) ? (last ? DONE : RUN) : (alu.start ? RUN : IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture and serial datapath; a new accept in DONE overwrites operands after the old carry is read
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
`ifdef SERIAL_ALU_SUB_EN
            op_q    <= OP_ADD;
`endif
        end else if (accept) begin
            a_q     <= alu.a;
            b_q     <= alu.b;
            cnt_q   <= '0;
`ifdef SERIAL_ALU_SUB_EN
            op_q    <= alu.op;
            carry_q <= (alu.op == OP_SUB);
`else
            carry_q <= OP_ADD;
`endif
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
            carry_q <= c_bit;
            cnt_q   <= cnt_q + CW'(1);
            if (last) cmsb_q <= carry_q;
        end
    end

    // Visible outputs update only when leaving DONE, so done pulses once per finished operation
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                result_q <= sum_q;
                cout_q   <= carry_q;
                ovf_q    <= carry_q ^ cmsb_q;
            end
        end
    end

    assign alu.busy     = (state_q == RUN);
    assign alu.done     = done_q;
    assign alu.result   = result_q;
    assign alu.cout     = cout_q;
    assign alu.overflow = ovf_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed and random checks of serial_alu_ctrl against an integer-arithmetic reference
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_alu_if #(.WIDTH(W)) alu ();
    serial_alu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .alu(alu));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands
    task automatic ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          output logic [W-1:0] r, output logic c, output logic v);
        int sx, sy, sv;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sv = o ? sx - sy : sx + sy;
        v  = (sv > 2 ** (W - 1) - 1) || (sv < -(2 ** (W - 1)));
        c  = o ? (x >= y) : (int'(x) + int'(y) >= 2 ** W);
        r  = o ? x - y : x + y;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        alu.a = x;
        alu.b = y;
`ifdef SERIAL_ALU_SUB_EN
        alu.op = o;
`else
        if (o) $display("note: subtract requested in add-only build");
`endif
    endtask

    function automatic logic rand_op();
`ifdef SERIAL_ALU_SUB_EN
        return 1'($urandom);
`else
        return 1'b0;
`endif
    endfunction

    // One operation from IDLE; mid_k > 0 raises an extra start (a=8'h11) in that RUN cycle
    task automatic op_run(input logic [W-1:0] x, input logic [W-1:0] y, input logic o, input int mid_k);
        logic [W-1:0] er;
        logic         ec, ev;
        int           busy_n, done_at;
        ref_op(x, y, o, er, ec, ev);
        @(negedge clk);
        alu.start = 1'b1;
        drive(x, y, o);
        @(posedge clk); #1;
        alu.start = 1'b0;
        drive(W'($urandom), W'($urandom), rand_op());
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= W + 3 && done_at == 0; k++) begin
            if (alu.busy) busy_n++;
            if (k == mid_k) begin
                alu.start = 1'b1;
                alu.a     = 8'h11;
            end
            @(posedge clk); #1;
            alu.start = 1'b0;
            if (alu.done) done_at = k;
        end
        check("latency", 32'(done_at), 32'(W + 1));
        check("busy_cycles", 32'(busy_n), 32'(W));
        check("result", 32'(alu.result), 32'(er));
        check("cout", 32'(alu.cout), 32'(ec));
        check("overflow", 32'(alu.overflow), 32'(ev));
        check("busy_at_done", 32'(alu.busy), 32'(0));
        @(posedge clk); #1;
        check("done_single", 32'(alu.done), 32'(0));
        check("result_hold", 32'(alu.result), 32'(er));
    endtask

    initial begin
        logic [W-1:0] cx, cy, nx, ny, er;
        logic         co, no, ec, ev;
        int           dn;
        rst = 1'b1;
        alu.start = 1'b0;
        drive('0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(alu.busy), 32'(0));
        check("rst_done", 32'(alu.done), 32'(0));
        check("rst_result", 32'(alu.result), 32'(0));
        check("rst_cout", 32'(alu.cout), 32'(0));
        check("rst_ovf", 32'(alu.overflow), 32'(0));
        rst = 1'b0;

        op_run(8'h3C, 8'h05, 1'b0, 0);
        op_run(8'hFF, 8'h01, 1'b0, 0);
`ifdef SERIAL_ALU_SUB_EN
        op_run(8'h80, 8'h01, 1'b1, 0);
        op_run(8'h00, 8'h01, 1'b1, 0);
`endif
        op_run(8'h01, 8'h02, 1'b0, 3);
        op_run(8'h7F, 8'h01, 1'b0, 0);

        // Abort in the 4th RUN cycle; prior result 8'h80 with overflow must be cleared
        @(negedge clk);
        alu.start = 1'b1;
        drive(8'h55, 8'h22, 1'b0);
        @(posedge clk); #1;
        alu.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(alu.busy), 32'(0));
        check("abort_done", 32'(alu.done), 32'(0));
        check("abort_result", 32'(alu.result), 32'(0));
        check("abort_cout", 32'(alu.cout), 32'(0));
        check("abort_ovf", 32'(alu.overflow), 32'(0));
        dn = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            dn += int'(alu.done);
        end
        check("abort_no_done", 32'(dn), 32'(0));
        op_run(8'h0A, 8'h0B, 1'b0, 0);

        for (int i = 0; i < 24; i++) op_run(W'($urandom), W'($urandom), rand_op(), 0);

        // start held high: a new operation is accepted in every DONE cycle
        cx = W'($urandom);
        cy = W'($urandom);
        co = rand_op();
        @(negedge clk);
        alu.start = 1'b1;
        drive(cx, cy, co);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            ref_op(cx, cy, co, er, ec, ev);
            nx = W'($urandom);
            ny = W'($urandom);
            no = rand_op();
            drive(nx, ny, no);
            dn = 0;
            repeat (W) begin
                @(posedge clk); #1;
                dn += int'(alu.done);
            end
            check("b2b_early_done", 32'(dn), 32'(0));
            @(posedge clk); #1;
            check("b2b_done", 32'(alu.done), 32'(1));
            check("b2b_result", 32'(alu.result), 32'(er));
            check("b2b_cout", 32'(alu.cout), 32'(ec));
            check("b2b_ovf", 32'(alu.overflow), 32'(ev));
            check("b2b_busy", 32'(alu.busy), 32'(1));
            cx = nx;
            cy = ny;
            co = no;
        end
        alu.start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        check("drain_idle", 32'(alu.busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
